// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// Holds the ecall FSM state enum, the pending-write count type and register constants.
package hazard_ctrl_pkg;

    localparam int         NUM_REGS = 32;
    localparam logic [4:0] REG_X0   = 5'd0;

    typedef logic [1:0] pend_cnt_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } hc_state_t;

endpackage

// File: rtl/hc_scoreboard.sv
// Per-register pending-write counters for x1..x31; x0 is never tracked.
// Ports: clk, reset (sync, active-high), i_inc_en/i_inc_rd (issue),
//        i_dec_en/i_dec_rd (writeback), o_cnt (all counters), o_sb_empty.
import hazard_ctrl_pkg::*;

module hc_scoreboard (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_inc_en,
    input  logic [4:0]                i_inc_rd,
    input  logic                      i_dec_en,
    input  logic [4:0]                i_dec_rd,
    output pend_cnt_t [NUM_REGS-1:0]  o_cnt,
    output logic                      o_sb_empty
);

    pend_cnt_t [NUM_REGS-1:0] r_cnt;
    logic      [NUM_REGS-1:0] w_inc;
    logic      [NUM_REGS-1:0] w_dec;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (i_inc_en) w_inc[i_inc_rd] = 1'b1;
        if (i_dec_en) w_dec[i_dec_rd] = 1'b1;
        w_inc[0] = 1'b0;
        w_dec[0] = 1'b0;
    end

    // Same-register issue and retire in one cycle cancel out.
    // Retire of an idle register saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + 2'd1;
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 2'd0))
                    r_cnt[i] <= r_cnt[i] - 2'd1;
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_sb_empty = (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW/WAW stalls, branch flush, ecall drain FSM.
// Ports: clk, reset (sync, active-high), id_* decode info, ex_branch_taken,
//        wb_valid/wb_rd, ecall_done; outputs id_issue, id_stall, if_stall,
//        id_flush, ecall_req, sb_empty.
// Macro HAZARD_CTRL_BYPASS_EN: RAW stalls only on load-use (one cycle).
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_wr_en,
    input  logic       id_is_load,
    input  logic       id_is_ecall,
    input  logic       ex_branch_taken,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       ecall_done,
    output logic       id_issue,
    output logic       id_stall,
    output logic       if_stall,
    output logic       id_flush,
    output logic       ecall_req,
    output logic       sb_empty
);

    localparam pend_cnt_t MAX_CNT = pend_cnt_t'(MAX_INFLIGHT);

    pend_cnt_t [NUM_REGS-1:0] w_cnt;
    logic                     w_sb_empty;
    hc_state_t                r_state;
    hc_state_t                w_state_nxt;
    logic                     r_load_in_ex;
    logic      [4:0]          r_load_rd;
    logic                     w_flush;
    logic                     w_raw;
    logic                     w_waw;
    logic                     w_fsm_stall;
    logic                     w_stall;
    logic                     w_issue;

    hc_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_inc_en   (w_issue && id_wr_en && (id_rd != REG_X0)),
        .i_inc_rd   (id_rd),
        .i_dec_en   (wb_valid && (wb_rd != REG_X0)),
        .i_dec_rd   (wb_rd),
        .o_cnt      (w_cnt),
        .o_sb_empty (w_sb_empty)
    );

    assign w_flush = ~reset & ex_branch_taken & id_valid;

`ifdef HAZARD_CTRL_BYPASS_EN
    // Everything but a load result one cycle old is forwarded.
    assign w_raw = r_load_in_ex && (r_load_rd != REG_X0) &&
                   ((id_rs1 == r_load_rd) || (id_rs2 == r_load_rd));
`else
    assign w_raw = ((id_rs1 != REG_X0) && (w_cnt[id_rs1] != 2'd0)) ||
                   ((id_rs2 != REG_X0) && (w_cnt[id_rs2] != 2'd0));
`endif

    assign w_waw = id_wr_en && (w_cnt[id_rd] == MAX_CNT);

    always_comb begin
        w_state_nxt = r_state;
        w_fsm_stall = 1'b0;
        unique case (r_state)
            RUN: begin
                if (id_valid && id_is_ecall && !w_flush) begin
                    w_fsm_stall = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_fsm_stall = 1'b1;
                if (w_flush)
                    w_state_nxt = RUN;
                else if (w_sb_empty)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_flush || ecall_done)
                    w_state_nxt = RUN;
                else
                    w_fsm_stall = 1'b1;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // A flush wins over any stall so the NOP can replace decode.
    assign w_stall = ~reset & id_valid & ~w_flush &
                     (w_fsm_stall | ((r_state == RUN) & (w_raw | w_waw)));
    assign w_issue = ~reset & id_valid & ~w_stall & ~w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_load_in_ex <= 1'b0;
            r_load_rd    <= REG_X0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_in_ex <= w_issue & id_is_load;
            if (w_issue && id_is_load)
                r_load_rd <= id_rd;
        end
    end

    assign id_issue  = w_issue;
    assign id_stall  = w_stall;
    assign if_stall  = w_stall;
    assign id_flush  = w_flush;
    assign ecall_req = ~reset & (r_state == WAIT);
    assign sb_empty  = reset | w_sb_empty;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Covers reset, RAW, load-use, WAW, flush, ecall drain and reset in WAIT.
import hazard_ctrl_pkg::*;

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_wr_en, id_is_load, id_is_ecall;
    logic       ex_branch_taken;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       ecall_done;
    logic       id_issue, id_stall, if_stall, id_flush, ecall_req, sb_empty;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MAX_INFLIGHT(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_wr_en        (id_wr_en),
        .id_is_load      (id_is_load),
        .id_is_ecall     (id_is_ecall),
        .ex_branch_taken (ex_branch_taken),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .ecall_done      (ecall_done),
        .id_issue        (id_issue),
        .id_stall        (id_stall),
        .if_stall        (if_stall),
        .id_flush        (id_flush),
        .ecall_req       (ecall_req),
        .sb_empty        (sb_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle();
        id_valid        = 1'b0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_rd           = 5'd0;
        id_wr_en        = 1'b0;
        id_is_load      = 1'b0;
        id_is_ecall     = 1'b0;
        ex_branch_taken = 1'b0;
        wb_valid        = 1'b0;
        wb_rd           = 5'd0;
        ecall_done      = 1'b0;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic ec);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_wr_en    = we;
        id_is_load  = ld;
        id_is_ecall = ec;
    endtask

    task automatic wbc(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        adv();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        drv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
        ex_branch_taken = 1'b1;
        adv();
        adv();
        settle();
        checks++; if (id_issue !== 1'b0) begin errors++; $display("FAIL rst_issue got %b exp 0", id_issue); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", id_stall); end
        checks++; if (if_stall !== 1'b0) begin errors++; $display("FAIL rst_if_stall got %b exp 0", if_stall); end
        checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", id_flush); end
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL rst_ecall_req got %b exp 0", ecall_req); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rst_sb_empty got %b exp 1", sb_empty); end
        adv();
        reset = 1'b0;
        idle();
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL post_rst_empty got %b exp 1", sb_empty); end
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL post_rst_req got %b exp 0", ecall_req); end
        adv();
    endtask

    task automatic test_raw();
        drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL raw_wr_issue got %b exp 1", id_issue); end
        adv();
        drv(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
`ifdef HAZARD_CTRL_BYPASS_EN
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL raw_byp_issue got %b exp 1", id_issue); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL raw_byp_stall got %b exp 0", id_stall); end
        adv();
        idle();
        wbc(5'd5);
`else
        for (int k = 0; k < 2; k++) begin
            checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL raw_stall%0d got %b exp 1", k, id_stall); end
            checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL raw_if_stall%0d got %b exp 1", k, if_stall); end
            checks++; if (id_issue !== 1'b0) begin errors++; $display("FAIL raw_issue%0d got %b exp 0", k, id_issue); end
            adv();
            settle();
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL raw_same_cyc_wb got %b exp 1", id_stall); end
        adv();
        wb_valid = 1'b0;
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", id_issue); end
        adv();
        idle();
`endif
        wbc(5'd6);
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL raw_clean got %b exp 1", sb_empty); end
        adv();
    endtask

    task automatic test_load_use();
        drv(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL lu_load_issue got %b exp 1", id_issue); end
        adv();
        drv(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        settle();
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall0 got %b exp 1", id_stall); end
        adv();
        settle();
`ifdef HAZARD_CTRL_BYPASS_EN
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL lu_byp_issue got %b exp 1", id_issue); end
        adv();
        idle();
        wbc(5'd7);
`else
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got %b exp 1", id_stall); end
        adv();
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        settle();
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_wb got %b exp 1", id_stall); end
        adv();
        wb_valid = 1'b0;
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL lu_issue got %b exp 1", id_issue); end
        adv();
        idle();
`endif
        wbc(5'd8);
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL lu_clean got %b exp 1", sb_empty); end
        adv();
    endtask

    task automatic test_waw();
        drv(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL waw_issue%0d got %b exp 1", k, id_issue); end
            adv();
        end
        settle();
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", id_stall); end
        adv();
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        settle();
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_wb got %b exp 1", id_stall); end
        adv();
        wb_valid = 1'b0;
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL waw_release got %b exp 1", id_issue); end
        adv();
        idle();
        wbc(5'd9);
        wbc(5'd9);
        settle();
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL waw_one_left got %b exp 0", sb_empty); end
        adv();
        wbc(5'd9);
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL waw_clean got %b exp 1", sb_empty); end
        adv();
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL x0_issue got %b exp 1", id_issue); end
        adv();
        idle();
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL x0_untracked got %b exp 1", sb_empty); end
        adv();
        drv(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        adv();
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL incdec_issue got %b exp 1", id_issue); end
        adv();
        idle();
        settle();
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL incdec_held got %b exp 0", sb_empty); end
        adv();
        wbc(5'd4);
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL incdec_clean got %b exp 1", sb_empty); end
        adv();
    endtask

    task automatic test_saturate();
`ifndef HAZARD_CTRL_BYPASS_EN
        idle();
        wbc(5'd3);
        drv(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b exp 1", id_stall); end
        adv();
        idle();
        wbc(5'd3);
        drv(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL sat_issue got %b exp 1", id_issue); end
        adv();
        idle();
`endif
    endtask

    task automatic test_flush();
        drv(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd0, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
        settle();
`ifndef HAZARD_CTRL_BYPASS_EN
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL fl_pre_stall got %b exp 1", id_stall); end
`endif
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL fl_flush got %b exp 1", id_flush); end
        checks++; if (id_issue !== 1'b0) begin errors++; $display("FAIL fl_issue got %b exp 0", id_issue); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", id_stall); end
        adv();
        id_valid = 1'b0;
        settle();
        checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL fl_novalid got %b exp 0", id_flush); end
        adv();
        idle();
        settle();
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL fl_cnt_kept got %b exp 0", sb_empty); end
        adv();
        wbc(5'd10);
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fl_no_rd11 got %b exp 1", sb_empty); end
        adv();
    endtask

    task automatic test_ecall();
        drv(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ec_run_stall got %b exp 1", id_stall); end
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL ec_run_req got %b exp 0", ecall_req); end
        adv();
        ecall_done = 1'b1;
        wb_valid   = 1'b1;
        wb_rd      = 5'd12;
        settle();
        checks++; if (id_issue !== 1'b0) begin errors++; $display("FAIL ec_done_ignored got %b exp 0", id_issue); end
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ec_drain_stall0 got %b exp 1", id_stall); end
        adv();
        ecall_done = 1'b0;
        wb_rd      = 5'd13;
        settle();
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL ec_drain_req got %b exp 0", ecall_req); end
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL ec_drain_busy got %b exp 0", sb_empty); end
        adv();
        wb_valid = 1'b0;
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL ec_drained got %b exp 1", sb_empty); end
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL ec_drained_req got %b exp 0", ecall_req); end
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ec_drained_stall got %b exp 1", id_stall); end
        adv();
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++; if (ecall_req !== 1'b1) begin errors++; $display("FAIL ec_wait_req%0d got %b exp 1", k, ecall_req); end
            checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ec_wait_stall%0d got %b exp 1", k, id_stall); end
            adv();
        end
        ecall_done = 1'b1;
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL ec_issue got %b exp 1", id_issue); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL ec_release got %b exp 0", id_stall); end
        adv();
        idle();
        settle();
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL ec_req_drop got %b exp 0", ecall_req); end
        adv();
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL ec_back_run got %b exp 1", id_issue); end
        adv();
        idle();
    endtask

    task automatic test_reset_wait();
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        adv();
        adv();
        settle();
        checks++; if (ecall_req !== 1'b1) begin errors++; $display("FAIL rw_in_wait got %b exp 1", ecall_req); end
        adv();
        reset = 1'b1;
        settle();
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL rw_rst_req got %b exp 0", ecall_req); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rw_rst_empty got %b exp 1", sb_empty); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rw_rst_stall got %b exp 0", id_stall); end
        adv();
        reset = 1'b0;
        idle();
        settle();
        checks++; if (ecall_req !== 1'b0) begin errors++; $display("FAIL rw_after_req got %b exp 0", ecall_req); end
        checks++; if (dut.r_state !== RUN) begin errors++; $display("FAIL rw_state got %0d exp %0d", dut.r_state, RUN); end
        adv();
        drv(1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL rw_wr_issue got %b exp 1", id_issue); end
        adv();
        reset = 1'b1;
        drv(1'b1, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (id_issue !== 1'b0) begin errors++; $display("FAIL rw_rst_issue got %b exp 0", id_issue); end
        adv();
        reset = 1'b0;
        settle();
        checks++; if (id_issue !== 1'b1) begin errors++; $display("FAIL rw_cnt_cleared got %b exp 1", id_issue); end
        adv();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_load_use();
        test_waw();
        test_saturate();
        test_flush();
        test_ecall();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
